// File: rtl/player_hit_detector.sv
// Enemy-missile hit detector for the player ship: overlap test, life count,
// blinking invulnerability window after each hit, and a latched game-over state.
module player_hit_detector #(
    parameter int MISSILE_W     = 4,
    parameter int MISSILE_H     = 16,
    parameter int PLAYER_W      = 48,
    parameter int PLAYER_H      = 64,
    parameter int LIVES_INIT    = 3,
    parameter int INVULN_CYCLES = 65_000_000,
    parameter int BLINK_CYCLES  = 4_062_500
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [11:0] missile_x,
    input  logic [11:0] missile_y,
    input  logic        missile_on,
    input  logic [11:0] player_x,
    input  logic [11:0] player_y,
    input  logic        restart,
    output logic        hit_pulse,
    output logic        missile_kill,
    output logic [1:0]  lives,
    output logic        player_visible,
    output logic        game_over
);

    localparam int IW = (INVULN_CYCLES > 1) ? $clog2(INVULN_CYCLES) : 1;
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    typedef enum logic [1:0] {ALIVE, HIT, INVULN, DEAD} state_t;

    state_t        state, state_d;
    logic [IW-1:0] invuln_cnt, invuln_cnt_d;
    logic [BW-1:0] blink_cnt, blink_cnt_d;
    logic          hit_pulse_d, missile_kill_d, player_visible_d, game_over_d;
    logic [1:0]    lives_d;
    logic          hit_cand_q;
    logic          overlap;

    // 13-bit sums keep the right/bottom edges from wrapping near 4095.
    logic [12:0] mx, my, px, py;
    assign mx = {1'b0, missile_x};
    assign my = {1'b0, missile_y};
    assign px = {1'b0, player_x};
    assign py = {1'b0, player_y};

    assign overlap = (mx < px + 13'(PLAYER_W)) && (mx + 13'(MISSILE_W) > px) &&
                     (my < py + 13'(PLAYER_H)) && (my + 13'(MISSILE_H) > py);

    always_ff @(posedge pclk) begin
        if (rst) hit_cand_q <= 1'b0;
        else     hit_cand_q <= overlap & missile_on;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state          <= ALIVE;
            invuln_cnt     <= '0;
            blink_cnt      <= '0;
            hit_pulse      <= 1'b0;
            missile_kill   <= 1'b0;
            lives          <= 2'(LIVES_INIT);
            player_visible <= 1'b1;
            game_over      <= 1'b0;
        end else begin
            state          <= state_d;
            invuln_cnt     <= invuln_cnt_d;
            blink_cnt      <= blink_cnt_d;
            hit_pulse      <= hit_pulse_d;
            missile_kill   <= missile_kill_d;
            lives          <= lives_d;
            player_visible <= player_visible_d;
            game_over      <= game_over_d;
        end
    end

    always_comb begin
        state_d          = state;
        invuln_cnt_d     = invuln_cnt;
        blink_cnt_d      = blink_cnt;
        hit_pulse_d      = 1'b0;
        missile_kill_d   = 1'b0;
        lives_d          = lives;
        player_visible_d = player_visible;
        game_over_d      = game_over;
        case (state)
            ALIVE: begin
                player_visible_d = 1'b1;
                if (hit_cand_q && lives != 2'd0) begin
                    state_d        = HIT;
                    hit_pulse_d    = 1'b1;
                    missile_kill_d = 1'b1;
                    lives_d        = lives - 2'd1;
                end
            end
            HIT: begin
                invuln_cnt_d     = '0;
                blink_cnt_d      = '0;
                player_visible_d = 1'b0;
                if (lives == 2'd0) begin
                    state_d     = DEAD;
                    game_over_d = 1'b1;
                end else begin
                    state_d = INVULN;
                end
            end
            INVULN: begin
                // Missile passes through here; the controller is expected to retire it.
                if (invuln_cnt == IW'(INVULN_CYCLES - 1)) begin
                    state_d          = ALIVE;
                    invuln_cnt_d     = '0;
                    blink_cnt_d      = '0;
                    player_visible_d = 1'b1;
                end else begin
                    invuln_cnt_d = invuln_cnt + 1'b1;
                    if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
                        blink_cnt_d      = '0;
                        player_visible_d = ~player_visible;
                    end else begin
                        blink_cnt_d = blink_cnt + 1'b1;
                    end
                end
            end
            DEAD: begin
                game_over_d      = 1'b1;
                player_visible_d = 1'b0;
                lives_d          = 2'd0;
                if (restart) begin
                    state_d          = ALIVE;
                    lives_d          = 2'(LIVES_INIT);
                    game_over_d      = 1'b0;
                    player_visible_d = 1'b1;
                    invuln_cnt_d     = '0;
                    blink_cnt_d      = '0;
                end
            end
            default: state_d = ALIVE;
        endcase
    end

endmodule

// File: tb/tb_player_hit_detector.sv
// Directed bench for player_hit_detector with a short invulnerability window.
module tb_player_hit_detector;
    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] missile_x = '0, missile_y = '0, player_x = '0, player_y = '0;
    logic        missile_on = 1'b0, restart = 1'b0;
    logic        hit_pulse, missile_kill, player_visible, game_over;
    logic [1:0]  lives;

    int passed = 0;
    int total  = 0;

    player_hit_detector #(
        .MISSILE_W(4), .MISSILE_H(16), .PLAYER_W(48), .PLAYER_H(64),
        .LIVES_INIT(3), .INVULN_CYCLES(20), .BLINK_CYCLES(5)
    ) dut (
        .pclk(pclk), .rst(rst),
        .missile_x(missile_x), .missile_y(missile_y), .missile_on(missile_on),
        .player_x(player_x), .player_y(player_y), .restart(restart),
        .hit_pulse(hit_pulse), .missile_kill(missile_kill), .lives(lives),
        .player_visible(player_visible), .game_over(game_over)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [11:0] mx, my, px, py;
        logic        on;
        logic        hit;
    } vec_t;
    vec_t vecs[12];

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_in(input logic [11:0] mx, my, px, py, input logic on);
        missile_x = mx; missile_y = my; player_x = px; player_y = py; missile_on = on;
    endtask

    initial begin
        vecs[0]  = '{12'd148, 12'd700, 12'd100, 12'd700, 1'b1, 1'b0};
        vecs[1]  = '{12'd147, 12'd700, 12'd100, 12'd700, 1'b1, 1'b1};
        vecs[2]  = '{12'd96,  12'd700, 12'd100, 12'd700, 1'b1, 1'b0};
        vecs[3]  = '{12'd97,  12'd700, 12'd100, 12'd700, 1'b1, 1'b1};
        vecs[4]  = '{12'd120, 12'd764, 12'd100, 12'd700, 1'b1, 1'b0};
        vecs[5]  = '{12'd120, 12'd763, 12'd100, 12'd700, 1'b1, 1'b1};
        vecs[6]  = '{12'd120, 12'd684, 12'd100, 12'd700, 1'b1, 1'b0};
        vecs[7]  = '{12'd120, 12'd685, 12'd100, 12'd700, 1'b1, 1'b1};
        vecs[8]  = '{12'd120, 12'd720, 12'd100, 12'd700, 1'b0, 1'b0};
        vecs[9]  = '{12'd10,  12'd10,  12'd4080, 12'd4080, 1'b1, 1'b0};
        vecs[10] = '{12'd4090, 12'd4090, 12'd4080, 12'd4080, 1'b1, 1'b1};
        vecs[11] = '{12'd4095, 12'd4095, 12'd0, 12'd0, 1'b1, 1'b0};

        // Reset state
        do_reset();
        check("rst_pulse", hit_pulse, 0);
        check("rst_kill", missile_kill, 0);
        check("rst_lives", lives, 3);
        check("rst_vis", player_visible, 1);
        check("rst_go", game_over, 0);

        // Overlap table: hit appears exactly two edges after the inputs change
        foreach (vecs[i]) begin
            do_reset();
            set_in(vecs[i].mx, vecs[i].my, vecs[i].px, vecs[i].py, vecs[i].on);
            tick();
            check($sformatf("v%0d_early", i), hit_pulse, 0);
            tick();
            check($sformatf("v%0d_pulse", i), hit_pulse, vecs[i].hit);
            check($sformatf("v%0d_kill", i), missile_kill, vecs[i].hit);
            check($sformatf("v%0d_lives", i), lives, vecs[i].hit ? 2 : 3);
            tick();
            check($sformatf("v%0d_drop", i), hit_pulse, 0);
        end

        // missile_on gating over a long stretch
        do_reset();
        set_in(12'd120, 12'd720, 12'd100, 12'd700, 1'b0);
        for (int c = 0; c < 50; c++) begin
            tick();
            if (hit_pulse) check("off_pulse", hit_pulse, 0);
        end
        check("off_lives", lives, 3);

        // Restart ignored in ALIVE
        do_reset();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("rsA_lives", lives, 3);
        check("rsA_vis", player_visible, 1);
        check("rsA_go", game_over, 0);

        // Invulnerability with continuous overlap, restart poked mid-window, then game over
        do_reset();
        set_in(12'd120, 12'd720, 12'd100, 12'd700, 1'b1);
        tick();
        check("inv_k", hit_pulse, 0);
        tick();
        check("inv_hit1", hit_pulse, 1);
        check("inv_lives1", lives, 2);
        for (int i = 0; i < 20; i++) begin
            restart = (i == 8);
            tick();
            check($sformatf("inv_vis%0d", i), player_visible, ((i / 5) % 2 == 1) ? 1 : 0);
            if (hit_pulse || missile_kill) check($sformatf("inv_nohit%0d", i), 1, 0);
        end
        restart = 1'b0;
        check("inv_lives_hold", lives, 2);
        tick();
        check("alive_again_pulse", hit_pulse, 0);
        check("alive_again_vis", player_visible, 1);
        tick();
        check("inv_hit2", hit_pulse, 1);
        check("inv_lives2", lives, 1);
        for (int i = 0; i < 21; i++) begin
            tick();
            if (hit_pulse) check("inv2_nohit", 1, 0);
        end
        tick();
        check("hit3_pulse", hit_pulse, 1);
        check("hit3_lives", lives, 0);
        check("hit3_go", game_over, 0);
        tick();
        check("dead_go", game_over, 1);
        check("dead_vis", player_visible, 0);
        check("dead_pulse", hit_pulse, 0);
        for (int i = 0; i < 30; i++) begin
            tick();
            if (hit_pulse || missile_kill || lives != 2'd0) check("dead_ignore", 1, 0);
        end
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("rs_lives", lives, 3);
        check("rs_go", game_over, 0);
        check("rs_vis", player_visible, 1);
        tick();
        check("rs_alive_hit", hit_pulse, 1);
        check("rs_alive_lives", lives, 2);

        // Reset mid-INVULN
        do_reset();
        set_in(12'd120, 12'd720, 12'd100, 12'd700, 1'b1);
        tick();
        tick();
        tick();
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rsti_lives", lives, 3);
        check("rsti_vis", player_visible, 1);
        check("rsti_pulse", hit_pulse, 0);
        check("rsti_go", game_over, 0);
        tick();
        check("rsti_k", hit_pulse, 0);
        tick();
        check("rsti_hit", hit_pulse, 1);
        check("rsti_hit_lives", lives, 2);

        // Reset mid-HIT cuts the pulse short
        do_reset();
        set_in(12'd120, 12'd720, 12'd100, 12'd700, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_in(12'd0, 12'd0, 12'd100, 12'd700, 1'b0);
        check("rsth_pulse", hit_pulse, 0);
        check("rsth_kill", missile_kill, 0);
        check("rsth_lives", lives, 3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
